// File: rtl/pong_pkg.sv
// Shared constants for the pong game-flow controller: FSM state codes,
// datapath widths and active-low 7-segment glyphs (bit 0 = a .. bit 6 = g).
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int COORD_W = 12;

  localparam logic [1:0] ST_SERVE    = 2'd0;
  localparam logic [1:0] ST_PLAY     = 2'd1;
  localparam logic [1:0] ST_POINT    = 2'd2;
  localparam logic [1:0] ST_GAMEOVER = 2'd3;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scores never exceed 15, so the tens digit is at most 1.
  function automatic logic [SCORE_W-1:0] score_units(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_W'(10)) ? v - SCORE_W'(10) : v;
  endfunction

  function automatic logic [SCORE_W-1:0] score_tens(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_W'(10)) ? SCORE_W'(1) : SCORE_W'(0);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decimal digit -> active-low 7-segment pattern; codes above 9 blank.
module seg7_decoder
  import pong_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/pong_score_keeper.sv
// Pong game-flow controller: serve/play/point/game-over sequencing and scoring.
// Optional score display on a 4-digit 7-segment panel when SCORE_7SEG_EN is defined.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter logic [COORD_W-1:0] TOP_LIMIT    = 12'd5,
  parameter logic [COORD_W-1:0] BOTTOM_LIMIT = 12'd475,
  parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd9,
  parameter logic [7:0]         HOLD_FRAMES  = 8'd60,
  parameter int                 REFRESH_BITS = 17
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_animate,
  input  logic               i_shoot_btn,
  input  logic [COORD_W-1:0] i_ball_y1,
  input  logic [COORD_W-1:0] i_ball_y2,
  output logic               o_ball_en,
  output logic               o_serve,
  output logic [SCORE_W-1:0] o_score_a,
  output logic [SCORE_W-1:0] o_score_b,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [1:0]         o_state,
  output logic [6:0]         o_seg,
  output logic [3:0]         o_an
);

  logic [1:0]         r_sync;
  logic               r_btn_prev;
  logic [1:0]         r_state;
  logic [SCORE_W-1:0] r_score_a;
  logic [SCORE_W-1:0] r_score_b;
  logic [7:0]         r_hold_cnt;
  logic               r_winner;
  logic               r_serve;

  logic               w_press;
  logic               w_hit_a;
  logic               w_hit_b;
  logic               w_hold_done;
  logic [SCORE_W-1:0] w_leader_score;

  // NOTE: reset is synchronous, so it only takes effect on a clock edge;
  // the synchroniser flops are cleared too so no stale press survives reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync     <= 2'b00;
      r_btn_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_shoot_btn};
      r_btn_prev <= r_sync[1];
    end
  end

  assign w_press        = r_sync[1] & ~r_btn_prev;
  assign w_hit_b        = i_animate && (i_ball_y2 >= BOTTOM_LIMIT);
  assign w_hit_a        = i_animate && (i_ball_y1 <= TOP_LIMIT);
  assign w_hold_done    = i_animate && (r_hold_cnt == HOLD_FRAMES - 8'd1);
  assign w_leader_score = r_winner ? r_score_b : r_score_a;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_SERVE;
      r_score_a  <= '0;
      r_score_b  <= '0;
      r_hold_cnt <= '0;
      r_winner   <= 1'b0;
      r_serve    <= 1'b1;
    end else begin
      r_serve <= 1'b0;
      case (r_state)
        ST_SERVE: begin
          if (w_press) begin
            r_state <= ST_PLAY;
            r_serve <= 1'b1;
          end
        end
        ST_PLAY: begin
          // Bottom exit wins when both bounds trip on the same frame.
          if (w_hit_b) begin
            if (r_score_b != WIN_SCORE) r_score_b <= r_score_b + SCORE_W'(1);
            r_winner <= 1'b1;
            r_state  <= ST_POINT;
          end else if (w_hit_a) begin
            if (r_score_a != WIN_SCORE) r_score_a <= r_score_a + SCORE_W'(1);
            r_winner <= 1'b0;
            r_state  <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (w_hold_done) begin
            r_hold_cnt <= '0;
            if (w_leader_score == WIN_SCORE) begin
              r_state <= ST_GAMEOVER;
            end else begin
              r_state <= ST_SERVE;
              r_serve <= 1'b1;
            end
          end else if (i_animate) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        ST_GAMEOVER: begin
          if (w_press) begin
            r_score_a <= '0;
            r_score_b <= '0;
            r_state   <= ST_SERVE;
            r_serve   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_ball_en   = (r_state == ST_PLAY);
  assign o_game_over = (r_state == ST_GAMEOVER);
  assign o_serve     = r_serve;
  assign o_score_a   = r_score_a;
  assign o_score_b   = r_score_b;
  assign o_winner    = r_winner;
  assign o_state     = r_state;

`ifdef SCORE_7SEG_EN
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [6:0]              r_seg;
  logic [3:0]              r_an;
  logic [1:0]              w_digit_sel;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg;

  assign w_digit_sel = r_refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    case (w_digit_sel)
      2'd0:    w_digit = score_units(r_score_a);
      2'd1:    w_digit = score_tens(r_score_a);
      2'd2:    w_digit = score_units(r_score_b);
      default: w_digit = score_tens(r_score_b);
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_refresh <= '0;
      r_seg     <= SEG_BLANK;
      r_an      <= 4'hF;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
      r_seg     <= w_seg;
      r_an      <= ~(4'b0001 << w_digit_sel);
    end
  end

  assign o_seg = r_seg;
  assign o_an  = r_an;
`else
  assign o_seg = SEG_BLANK;
  assign o_an  = 4'hF;
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// Self-checking bench for pong_score_keeper: directed vector table, hand-written
// point/hold/win/reset sequences, then randomized play against a reference model.
module tb_pong_score_keeper;
  import pong_pkg::*;

  localparam logic [3:0]  WIN  = 4'd2;
  localparam logic [7:0]  HOLD = 8'd60;
  localparam logic [11:0] TOPL = 12'd5;
  localparam logic [11:0] BOTL = 12'd475;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_animate = 1'b0;
  logic        i_shoot_btn = 1'b0;
  logic [11:0] i_ball_y1 = 12'd200;
  logic [11:0] i_ball_y2 = 12'd210;
  logic        o_ball_en, o_serve, o_game_over, o_winner;
  logic [3:0]  o_score_a, o_score_b, o_an;
  logic [1:0]  o_state;
  logic [6:0]  o_seg;

  always #5 clk = ~clk;

  pong_score_keeper #(
    .TOP_LIMIT    (TOPL),
    .BOTTOM_LIMIT (BOTL),
    .WIN_SCORE    (WIN),
    .HOLD_FRAMES  (HOLD),
    .REFRESH_BITS (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_animate   (i_animate),
    .i_shoot_btn (i_shoot_btn),
    .i_ball_y1   (i_ball_y1),
    .i_ball_y2   (i_ball_y2),
    .o_ball_en   (o_ball_en),
    .o_serve     (o_serve),
    .o_score_a   (o_score_a),
    .o_score_b   (o_score_b),
    .o_game_over (o_game_over),
    .o_winner    (o_winner),
    .o_state     (o_state),
    .o_seg       (o_seg),
    .o_an        (o_an)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs away from the edge, let one rising edge pass, return at the falling edge.
  task automatic step(input logic rst, input logic anim, input logic btn,
                      input logic [11:0] y1, input logic [11:0] y2);
    i_rst       = rst;
    i_animate   = anim;
    i_shoot_btn = btn;
    i_ball_y1   = y1;
    i_ball_y2   = y2;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release then press and hold; a press acts on the third edge after the raw rise.
  task automatic press_btn();
    repeat (2) step(1'b0, 1'b0, 1'b0, 12'd200, 12'd210);
    repeat (3) step(1'b0, 1'b0, 1'b1, 12'd200, 12'd210);
  endtask

  typedef struct {
    logic        rst, anim, btn;
    logic [11:0] y1, y2;
    logic [1:0]  st;
    logic [3:0]  sa, sb;
    logic        ben, serve;
  } vec_t;

  vec_t tbl [7];

  // Reference model: game modes and counters computed straight from the game rules.
  typedef enum int {M_SERVE, M_PLAY, M_POINT, M_OVER} mode_e;
  mode_e m_mode;
  int    m_sa, m_sb, m_frames;
  bit    m_win, m_serve;
  bit    m_raw[$];

  function automatic logic [1:0] mode_code(input mode_e m);
    case (m)
      M_SERVE: return 2'd0;
      M_PLAY:  return 2'd1;
      M_POINT: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit anim, input bit btn,
                            input int y1, input int y2);
    bit press;
    if (rst) begin
      m_mode = M_SERVE; m_sa = 0; m_sb = 0; m_frames = 0;
      m_win = 0; m_serve = 1; m_raw = '{0, 0, 0};
      return;
    end
    // m_raw[0] is the button one edge ago, [1] two edges ago, [2] three edges ago.
    press = m_raw[1] && !m_raw[2];
    m_raw.push_front(btn);
    void'(m_raw.pop_back());
    m_serve = 0;
    case (m_mode)
      M_SERVE: if (press) begin m_mode = M_PLAY; m_serve = 1; end
      M_PLAY: if (anim) begin
        if (y2 >= int'(BOTL)) begin
          if (m_sb < int'(WIN)) m_sb++;
          m_win = 1; m_mode = M_POINT; m_frames = 0;
        end else if (y1 <= int'(TOPL)) begin
          if (m_sa < int'(WIN)) m_sa++;
          m_win = 0; m_mode = M_POINT; m_frames = 0;
        end
      end
      M_POINT: if (anim) begin
        m_frames++;
        if (m_frames == int'(HOLD)) begin
          if ((m_win ? m_sb : m_sa) == int'(WIN)) m_mode = M_OVER;
          else begin m_mode = M_SERVE; m_serve = 1; end
        end
      end
      M_OVER: if (press) begin
        m_sa = 0; m_sb = 0; m_mode = M_SERVE; m_serve = 1;
      end
    endcase
  endtask

  initial begin
    //            rst   anim  btn   y1      y2      st  sa  sb  ben serve
    tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd200, 12'd210, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 12'd200, 12'd210, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 12'd200, 12'd210, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 12'd200, 12'd210, 2'd1, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 12'd400, 12'd480, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 12'd400, 12'd480, 2'd2, 4'd0, 4'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 12'd3,   12'd200, 2'd2, 4'd0, 4'd1, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst, tbl[i].anim, tbl[i].btn, tbl[i].y1, tbl[i].y2);
      check($sformatf("vec%0d", i),
            {o_state, o_score_a, o_score_b, o_ball_en, o_serve},
            {tbl[i].st, tbl[i].sa, tbl[i].sb, tbl[i].ben, tbl[i].serve});
      if (i == 0) begin
        check("reset_go_win", {o_game_over, o_winner}, 2'b00);
`ifdef SCORE_7SEG_EN
        check("reset_seg_an", {o_seg, o_an}, {7'h7F, 4'hF});
`else
        check("seg_an_off", {o_seg, o_an}, {7'h7F, 4'hF});
`endif
      end
    end
    check("b_point_winner", o_winner, 1'b1);

    press_btn();
    check("point_press_ignored", {o_state, o_serve}, {ST_POINT, 1'b0});
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b1, 1'b1, 12'd200, 12'd210);
      if (i == 59) check("hold_59", {o_state, o_serve}, {ST_POINT, 1'b0});
    end
    check("hold_60", {o_state, o_serve, o_ball_en}, {ST_SERVE, 1'b1, 1'b0});
    repeat (4) step(1'b0, 1'b0, 1'b1, 12'd200, 12'd210);
    check("held_btn_no_press", {o_state, o_serve}, {ST_SERVE, 1'b0});

    press_btn();
    check("serve_press", {o_state, o_serve}, {ST_PLAY, 1'b1});
    step(1'b0, 1'b0, 1'b1, 12'd3, 12'd100);
    check("no_strobe_no_point", {o_state, o_score_a}, {ST_PLAY, 4'd0});
    step(1'b0, 1'b1, 1'b1, 12'd3, 12'd100);
    check("a_scores", {o_state, o_score_a, o_score_b, o_winner}, {ST_POINT, 4'd1, 4'd1, 1'b0});
    repeat (60) step(1'b0, 1'b1, 1'b1, 12'd200, 12'd210);
    check("a_back_to_serve", {o_state, o_serve}, {ST_SERVE, 1'b1});

    press_btn();
    check("serve_press2", o_state, ST_PLAY);
    step(1'b0, 1'b1, 1'b1, 12'd0, 12'd479);
    check("both_bounds_b_only", {o_state, o_score_a, o_score_b, o_winner},
          {ST_POINT, 4'd1, 4'd2, 1'b1});
    repeat (60) step(1'b0, 1'b1, 1'b1, 12'd200, 12'd210);
    check("gameover", {o_state, o_game_over, o_winner, o_score_b, o_ball_en, o_serve},
          {ST_GAMEOVER, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0});
    repeat (5) step(1'b0, 1'b1, 1'b1, 12'd0, 12'd479);
    check("gameover_holds", {o_state, o_score_a, o_score_b}, {ST_GAMEOVER, 4'd1, 4'd2});

    press_btn();
    check("restart", {o_state, o_serve, o_score_a, o_score_b, o_game_over},
          {ST_SERVE, 1'b1, 4'd0, 4'd0, 1'b0});
    press_btn();
    check("play_before_reset", o_state, ST_PLAY);
    step(1'b1, 1'b1, 1'b1, 12'd200, 12'd480);
    check("mid_play_reset",
          {o_state, o_serve, o_score_a, o_score_b, o_winner, o_ball_en, o_game_over},
          {ST_SERVE, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b0, 1'b0, 12'd200, 12'd210);
    check("after_reset", {o_state, o_serve}, {ST_SERVE, 1'b0});

    // Randomized play against the reference model.
    begin
      logic        btn_lvl;
      logic        rst, anim;
      logic [11:0] y1, y2;
      int          kind;
      btn_lvl = 1'b0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
        rst  = (cyc == 0) || ($urandom_range(0, 999) == 0);
        anim = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) btn_lvl = ~btn_lvl;
        kind = $urandom_range(0, 9);
        case (kind)
          0: begin y1 = 12'($urandom_range(0, 8));     y2 = y1 + 12'd8; end
          1: begin y2 = 12'($urandom_range(468, 490)); y1 = y2 - 12'd8; end
          2: begin y1 = 12'($urandom_range(0, 4095));  y2 = 12'($urandom_range(0, 4095)); end
          default: begin y1 = 12'($urandom_range(100, 400)); y2 = y1 + 12'd8; end
        endcase
        step(rst, anim, btn_lvl, y1, y2);
        model_step(rst, anim, btn_lvl, int'(y1), int'(y2));
        check($sformatf("rand%0d", cyc),
              {o_state, o_score_a, o_score_b, o_ball_en, o_serve, o_game_over, o_winner},
              {mode_code(m_mode), 4'(m_sa), 4'(m_sb), (m_mode == M_PLAY), m_serve,
               (m_mode == M_OVER), m_win});
      end
    end

`ifdef SCORE_7SEG_EN
    check("an_one_hot_low", $countones(~o_an), 32'd1);
`else
    check("seg_an_off_end", {o_seg, o_an}, {7'h7F, 4'hF});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
